// File: rtl/scan_pkg.sv
// Shared types and elaboration helpers for the scan-test multiplier wrapper.
package scan_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, CAPT} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Used by the top to refuse chain counts that do not split the register evenly.
    function automatic bit chains_divide(input int w, input int chains);
        return (chains > 0) && (((2 * w) % chains) == 0);
    endfunction

endpackage

// File: rtl/scan_shift_ctrl.sv
// Pattern controller: sequences L shift cycles and one capture cycle per start.
module scan_shift_ctrl
    import scan_pkg::*;
#(
    parameter int L = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic scan_en,
    output logic shift_en,
    output logic capt_en,
    output logic busy,
    output logic done
);

    localparam int CW = clog2(L + 1);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= capt_en;
        end
    end

    // start takes priority over a manual shift in IDLE; both are ignored once a pattern runs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_en   = 1'b0;
        capt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end else if (scan_en) begin
                    shift_en = 1'b1;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                cnt_next = cnt + CW'(1);
                if (cnt == LAST) state_next = CAPT;
            end
            CAPT: begin
                capt_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/scan_chain_mult_ctrl.sv
// Scan wrapper around a W x W unsigned multiplier with CHAINS parallel scan chains.
module scan_chain_mult_ctrl
    import scan_pkg::*;
#(
    parameter int W      = 4,
    parameter int CHAINS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan_en,
    input  logic [CHAINS-1:0] scan_in,
    output logic [CHAINS-1:0] scan_out,
    output logic              busy,
    output logic              done
);

    localparam int L = (2 * W) / CHAINS;

    if (!chains_divide(W, CHAINS)) begin : g_bad_chains
        $error("scan_chain_mult_ctrl: CHAINS must divide 2*W");
    end

    logic [2*W-1:0] sr, sr_shift, product;
    logic           shift_en, capt_en;

    scan_shift_ctrl #(.L(L)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .scan_en  (scan_en),
        .shift_en (shift_en),
        .capt_en  (capt_en),
        .busy     (busy),
        .done     (done)
    );

    // Each chain shifts toward its own LSB, which is also its serial output.
    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
        assign sr_shift[c*L+L-1] = scan_in[c];
        if (L > 1) begin : g_body
            assign sr_shift[c*L+L-2 -: L-1] = sr[c*L+L-1 -: L-1];
        end
        assign scan_out[c] = sr[c*L];
    end

    assign product = {{W{1'b0}}, sr[W-1:0]} * {{W{1'b0}}, sr[2*W-1:W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (capt_en) begin
            sr <= product;
        end else if (shift_en) begin
            sr <= sr_shift;
        end
    end

endmodule

// File: tb/tb_scan_chain_mult_ctrl.sv
// Directed bench for the scan multiplier wrapper with one-chain and two-chain instances.
module tb_scan_chain_mult_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, scan_en1, busy1, done1;
    logic [0:0] scan_in1, scan_out1;
    logic       start2, scan_en2, busy2, done2;
    logic [1:0] scan_in2, scan_out2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_chain_mult_ctrl #(.W(4), .CHAINS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .scan_en(scan_en1),
        .scan_in(scan_in1), .scan_out(scan_out1), .busy(busy1), .done(done1)
    );

    scan_chain_mult_ctrl #(.W(4), .CHAINS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .scan_en(scan_en2),
        .scan_in(scan_in2), .scan_out(scan_out2), .busy(busy2), .done(done2)
    );

    // One pattern on the single-chain instance; load[j] is shifted in at the j-th shift edge
    // and unload[j] is what scan_out showed just before that edge.
    task automatic run1(input logic [7:0] load, input bit disturb, input bit se_at_start,
                        output logic [7:0] unload, output int busy_cycles,
                        output int done_count, output int done_at);
        busy_cycles = 0; done_count = 0; done_at = -1; unload = '0;
        start1 = 1'b1; scan_en1 = se_at_start; scan_in1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; scan_en1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            scan_in1 = load[j];
            if (disturb) begin
                start1   = j[0];
                scan_en1 = ~j[0];
            end
            unload[j] = scan_out1[0];
            if (busy1) busy_cycles++;
            if (done1) begin
                done_count++;
                if (done_at < 0) done_at = j;
            end
            @(negedge clk);
        end
        start1 = 1'b0; scan_en1 = 1'b0; scan_in1 = 1'b0;
        for (int n = 8; n < 14; n++) begin
            if (busy1) busy_cycles++;
            if (done1) begin
                done_count++;
                if (done_at < 0) done_at = n;
            end
            @(negedge clk);
        end
    endtask

    task automatic run2(input logic [7:0] load, output logic [7:0] unload,
                        output int busy_cycles, output int done_count, output int done_at);
        busy_cycles = 0; done_count = 0; done_at = -1; unload = '0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            scan_in2      = {load[4+j], load[j]};
            unload[j]     = scan_out2[0];
            unload[4+j]   = scan_out2[1];
            if (busy2) busy_cycles++;
            if (done2) begin
                done_count++;
                if (done_at < 0) done_at = j;
            end
            @(negedge clk);
        end
        scan_in2 = '0;
        for (int n = 4; n < 10; n++) begin
            if (busy2) busy_cycles++;
            if (done2) begin
                done_count++;
                if (done_at < 0) done_at = n;
            end
            @(negedge clk);
        end
    endtask

    // Manual unload of the single-chain register in IDLE, shifting zeros in behind it.
    task automatic unload1(output logic [7:0] v, output int busy_seen);
        busy_seen = 0;
        scan_in1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            v[j] = scan_out1[0];
            if (busy1) busy_seen++;
            scan_en1 = 1'b1;
            @(negedge clk);
        end
        scan_en1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy1, done1, scan_out1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_dut1: got busy/done/scan_out=%b expected 000", {busy1, done1, scan_out1});
        end
        checks++;
        if ({busy2, done2, scan_out2} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_dut2: got busy/done/scan_out=%b expected 0000", {busy2, done2, scan_out2});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_pattern();
        logic [7:0] u;
        int bc, dc, da;
        run1(8'h53, 1'b0, 1'b0, u, bc, dc, da);
        checks++;
        if (bc !== 9) begin failures++; $display("[TB] FAIL t1_busy_cycles: got %0d expected 9", bc); end
        checks++;
        if (dc !== 1) begin failures++; $display("[TB] FAIL t1_done_count: got %0d expected 1", dc); end
        checks++;
        if (da !== 9) begin failures++; $display("[TB] FAIL t1_done_latency: got %0d expected 9", da); end
        run1(8'h00, 1'b0, 1'b0, u, bc, dc, da);
        checks++;
        if (u !== 8'h0F) begin failures++; $display("[TB] FAIL t1_unload: got %h expected 0f", u); end
    endtask

    task automatic test_full_product();
        logic [7:0] u;
        int bc, dc, da, bs;
        run1(8'hFF, 1'b0, 1'b0, u, bc, dc, da);
        unload1(u, bs);
        checks++;
        if (u !== 8'hE1) begin failures++; $display("[TB] FAIL t2_product_15x15: got %h expected e1", u); end
        checks++;
        if (bs !== 0) begin failures++; $display("[TB] FAIL t2_busy_in_manual: got %0d expected 0", bs); end
    endtask

    task automatic test_two_chains();
        logic [7:0] u;
        int bc, dc, da;
        run2(8'h46, u, bc, dc, da);
        checks++;
        if (da !== 5) begin failures++; $display("[TB] FAIL t3_done_latency: got %0d expected 5", da); end
        checks++;
        if (bc !== 5) begin failures++; $display("[TB] FAIL t3_busy_cycles: got %0d expected 5", bc); end
        run2(8'h00, u, bc, dc, da);
        checks++;
        if (u[3:0] !== 4'b1000) begin failures++; $display("[TB] FAIL t3_unload_chain0: got %b expected 1000", u[3:0]); end
        checks++;
        if (u[7:4] !== 4'b0001) begin failures++; $display("[TB] FAIL t3_unload_chain1: got %b expected 0001", u[7:4]); end
    endtask

    task automatic test_ignore_during_shift();
        logic [7:0] u;
        int bc, dc, da;
        run1(8'h53, 1'b1, 1'b0, u, bc, dc, da);
        checks++;
        if (bc !== 9) begin failures++; $display("[TB] FAIL t4_busy_cycles: got %0d expected 9", bc); end
        checks++;
        if (dc !== 1) begin failures++; $display("[TB] FAIL t4_done_count: got %0d expected 1", dc); end
        run1(8'h00, 1'b0, 1'b0, u, bc, dc, da);
        checks++;
        if (u !== 8'h0F) begin failures++; $display("[TB] FAIL t4_unload: got %h expected 0f", u); end
    endtask

    task automatic test_reset_mid_pattern();
        logic [7:0] u;
        int bc, dc, da, bs;
        run1(8'h53, 1'b0, 1'b0, u, bc, dc, da);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; scan_in1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy1, scan_out1} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL t5_before_reset: got busy/scan_out=%b expected 11", {busy1, scan_out1});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, scan_out1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL t5_async_reset: got busy/done/scan_out=%b expected 000", {busy1, done1, scan_out1});
        end
        @(negedge clk);
        rst = 1'b0; scan_in1 = 1'b0;
        @(negedge clk);
        unload1(u, bs);
        checks++;
        if (u !== 8'h00) begin failures++; $display("[TB] FAIL t5_sr_cleared: got %h expected 00", u); end
        run1(8'h53, 1'b0, 1'b0, u, bc, dc, da);
        checks++;
        if (dc !== 1 || bc !== 9) begin
            failures++;
            $display("[TB] FAIL t5_restart: got done=%0d busy=%0d expected done=1 busy=9", dc, bc);
        end
        unload1(u, bs);
        checks++;
        if (u !== 8'h0F) begin failures++; $display("[TB] FAIL t5_restart_product: got %h expected 0f", u); end
    endtask

    task automatic test_manual_shift();
        logic [7:0] u;
        int bc, dc, da, bs;
        bs = 0;
        scan_in1 = 1'b1; scan_en1 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (busy1) bs++;
        end
        scan_en1 = 1'b0; scan_in1 = 1'b0;
        checks++;
        if (bs !== 0) begin failures++; $display("[TB] FAIL t6_busy_manual: got %0d expected 0", bs); end
        unload1(u, bs);
        checks++;
        if (u !== 8'hE0) begin failures++; $display("[TB] FAIL t6_manual_shift: got %h expected e0", u); end
        scan_in1 = 1'b1; scan_en1 = 1'b1;
        repeat (3) @(negedge clk);
        scan_en1 = 1'b0;
        run1(8'h00, 1'b0, 1'b1, u, bc, dc, da);
        checks++;
        if (u !== 8'hE0) begin failures++; $display("[TB] FAIL t6_start_beats_scan_en: got %h expected e0", u); end
        checks++;
        if (dc !== 1 || bc !== 9) begin
            failures++;
            $display("[TB] FAIL t6_pattern: got done=%0d busy=%0d expected done=1 busy=9", dc, bc);
        end
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; scan_en1 = 1'b0; scan_in1 = '0;
        start2 = 1'b0; scan_en2 = 1'b0; scan_in2 = '0;
        test_reset();
        test_basic_pattern();
        test_full_product();
        test_two_chains();
        test_ignore_during_shift();
        test_reset_mid_pattern();
        test_manual_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
